// File: rtl/exe_stage.sv
// Execute stage of the LA32R 5-stage pipeline: latches the decode bundle, runs the
// ALU, issues the data-SRAM request and returns forwarding/stall info to decode.
module exe_stage #(
  parameter int unsigned SRAM_WEN_W = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ms_allowin,
  output logic                  es_allowin,
  input  logic                  ds_to_es_valid,
  input  logic [150:0]          ds_to_es_bus,
  output logic                  es_to_ms_valid,
  output logic [70:0]           es_to_ms_bus,
  output logic [38:0]           es_to_ds_forward_bus,
  output logic                  es_to_ds_valid,
  output logic                  data_sram_en,
  output logic [SRAM_WEN_W-1:0] data_sram_we,
  output logic [31:0]           data_sram_addr,
  output logic [31:0]           data_sram_wdata
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NUM_OP = 12;
  localparam int unsigned SHW    = 5;

  typedef struct packed {
    logic [NUM_OP-1:0] alu_op;
    logic              load_op;
    logic              src1_is_pc;
    logic              src2_is_imm;
    logic              src2_is_4;
    logic              gr_we;
    logic              store_op;
    logic [4:0]        dest;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rj_value;
    logic [XLEN-1:0]   rkd_value;
    logic [XLEN-1:0]   pc;
  } ds_bus_t;

  logic    es_valid_q, es_valid_d;
  ds_bus_t bus_q, bus_d;
  logic    es_ready_go;

  assign es_ready_go = 1'b1;
  assign es_allowin  = !es_valid_q || (es_ready_go && ms_allowin);

  // Bundle only loads on an actual transfer so a stall holds the previous op intact.
  always_comb begin
    es_valid_d = es_valid_q;
    bus_d      = bus_q;
    if (es_allowin) begin
      es_valid_d = ds_to_es_valid;
    end
    if (ds_to_es_valid && es_allowin) begin
      bus_d = ds_bus_t'(ds_to_es_bus);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      es_valid_q <= 1'b0;
      bus_q      <= '0;
    end else begin
      es_valid_q <= es_valid_d;
      bus_q      <= bus_d;
    end
  end

  logic [XLEN-1:0] src1, src2;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] add_res, sub_res, slt_res, sltu_res;
  logic [XLEN-1:0] and_res, nor_res, or_res, xor_res;
  logic [XLEN-1:0] sll_res, srl_res, sra_res, lui_res;
  logic [XLEN-1:0] alu_result;

  assign src1  = bus_q.src1_is_pc  ? bus_q.pc  : bus_q.rj_value;
  assign src2  = bus_q.src2_is_imm ? bus_q.imm : bus_q.rkd_value;
  assign shamt = src2[SHW-1:0];

  assign add_res  = src1 + src2;
  assign sub_res  = src1 - src2;
  assign slt_res  = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
  assign sltu_res = {{(XLEN-1){1'b0}}, src1 < src2};
  assign and_res  = src1 & src2;
  assign nor_res  = ~(src1 | src2);
  assign or_res   = src1 | src2;
  assign xor_res  = src1 ^ src2;
  assign sll_res  = src1 << shamt;
  assign srl_res  = src1 >> shamt;
  assign sra_res  = XLEN'($signed(src1) >>> shamt);
  assign lui_res  = src2;

  // One-hot select; an empty op vector yields zero.
  always_comb begin
    alu_result = ({XLEN{bus_q.alu_op[0]}}  & add_res)
               | ({XLEN{bus_q.alu_op[1]}}  & sub_res)
               | ({XLEN{bus_q.alu_op[2]}}  & slt_res)
               | ({XLEN{bus_q.alu_op[3]}}  & sltu_res)
               | ({XLEN{bus_q.alu_op[4]}}  & and_res)
               | ({XLEN{bus_q.alu_op[5]}}  & nor_res)
               | ({XLEN{bus_q.alu_op[6]}}  & or_res)
               | ({XLEN{bus_q.alu_op[7]}}  & xor_res)
               | ({XLEN{bus_q.alu_op[8]}}  & sll_res)
               | ({XLEN{bus_q.alu_op[9]}}  & srl_res)
               | ({XLEN{bus_q.alu_op[10]}} & sra_res)
               | ({XLEN{bus_q.alu_op[11]}} & lui_res);
  end

  assign es_to_ms_valid = es_valid_q && es_ready_go;
  assign es_to_ds_valid = es_valid_q;
  assign es_to_ms_bus   = {bus_q.load_op, bus_q.gr_we, bus_q.dest, alu_result, bus_q.pc};

  // Access fires only in the cycle the op moves to MS, so it is issued exactly once.
  assign data_sram_en    = es_valid_q && (bus_q.load_op || bus_q.store_op) && ms_allowin;
  assign data_sram_we    = {SRAM_WEN_W{bus_q.store_op && data_sram_en}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = bus_q.rkd_value;

  // Loaded data only exists at WB, so a load in ES forces decode to stall.
  assign es_to_ds_forward_bus = {es_valid_q && bus_q.load_op,
                                 es_valid_q && bus_q.gr_we && (bus_q.dest != 5'd0),
                                 bus_q.dest, alu_result};

  logic unused_src2_is_4;
  assign unused_src2_is_4 = bus_q.src2_is_4;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: directed LA32R cases plus random traffic with MS back-pressure.
module tb_exe_stage;

  typedef struct packed {
    logic [70:0] ms_bus;
    logic [38:0] fwd;
    logic        mem;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic         ms_allowin = 1'b0;
  logic         es_allowin;
  logic         ds_to_es_valid = 1'b0;
  logic [150:0] ds_to_es_bus = '0;
  logic         es_to_ms_valid;
  logic [70:0]  es_to_ms_bus;
  logic [38:0]  es_to_ds_forward_bus;
  logic         es_to_ds_valid;
  logic         data_sram_en;
  logic [3:0]   data_sram_we;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;

  exe_stage #(.SRAM_WEN_W(4)) dut (
    .clk(clk), .resetn(resetn), .ms_allowin(ms_allowin), .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .es_to_ds_forward_bus(es_to_ds_forward_bus), .es_to_ds_valid(es_to_ds_valid),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3:  return (a < b) ? 32'd1 : 32'd0;
      4:  return a & b;
      5:  return ~(a | b);
      6:  return a | b;
      7:  return a ^ b;
      8:  return a << b[4:0];
      9:  return a >> b[4:0];
      10: return $unsigned($signed(a) >>> b[4:0]);
      11: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void mk_tx(input int op, input logic ld, input logic st, input logic s1pc,
                                input logic s2imm, input logic s24, input logic gwe,
                                input logic [4:0] dest, input logic [31:0] imm, input logic [31:0] rj,
                                input logic [31:0] rk, input logic [31:0] pc,
                                output logic [150:0] bus, output exp_t e);
    logic [11:0] oh;
    logic [31:0] r;
    oh = '0;
    if (op >= 0 && op < 12) oh[op] = 1'b1;
    r = ref_alu(op, s1pc ? pc : rj, s2imm ? imm : rk);
    bus = {oh, ld, s1pc, s2imm, s24, gwe, st, dest, imm, rj, rk, pc};
    e.ms_bus = {ld, gwe, dest, r, pc};
    e.fwd    = {ld, gwe && (dest != 5'd0), dest, r};
    e.mem    = ld || st;
    e.st     = st;
    e.addr   = r;
    e.wdata  = rk;
  endfunction

  // One cycle of stimulus; acceptance follows the bench's own occupancy model.
  task automatic step(input logic v, input logic [150:0] b, input exp_t e, input logic msa,
                      output logic acc);
    ds_to_es_valid = v;
    ds_to_es_bus   = b;
    ms_allowin     = msa;
    @(posedge clk);
    acc = v && (exp_q.size() == 0);
    if (acc) exp_q.push_back(e);
    #1;
  endtask

  // Monitor: compares whatever the stage currently presents against the queue head.
  always @(negedge clk) begin
    exp_t cur;
    if (resetn && mon_en) begin
      if (exp_q.size() == 0) begin
        check("ms_valid_idle", 72'(es_to_ms_valid), 72'd0);
        check("ds_valid_idle", 72'(es_to_ds_valid), 72'd0);
        check("allowin_idle", 72'(es_allowin), 72'd1);
        check("sram_en_idle", 72'(data_sram_en), 72'd0);
        check("fwd_flags_idle", 72'(es_to_ds_forward_bus[38:37]), 72'd0);
      end else begin
        cur = exp_q[0];
        check("ms_valid", 72'(es_to_ms_valid), 72'd1);
        check("ds_valid", 72'(es_to_ds_valid), 72'd1);
        check("allowin", 72'(es_allowin), 72'(ms_allowin));
        check("ms_bus", 72'(es_to_ms_bus), 72'(cur.ms_bus));
        check("fwd_bus", 72'(es_to_ds_forward_bus), 72'(cur.fwd));
        check("sram_en", 72'(data_sram_en), 72'(cur.mem && ms_allowin));
        check("sram_we", 72'(data_sram_we), (cur.st && ms_allowin) ? 72'hf : 72'h0);
        if (cur.mem && ms_allowin) begin
          check("sram_addr", 72'(data_sram_addr), 72'(cur.addr));
          if (cur.st) check("sram_wdata", 72'(data_sram_wdata), 72'(cur.wdata));
        end
        if (ms_allowin) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [150:0] b;
    exp_t         e;
    logic         acc;
    int           tries;
    int           op;
    logic         ld, st;

    #1 resetn = 1'b0;
    #2;
    check("rst_ms_valid", 72'(es_to_ms_valid), 72'd0);
    check("rst_ds_valid", 72'(es_to_ds_valid), 72'd0);
    check("rst_sram_en", 72'(data_sram_en), 72'd0);
    check("rst_allowin", 72'(es_allowin), 72'd1);
    check("rst_ms_bus", 72'(es_to_ms_bus), 72'd0);
    check("rst_fwd_bus", 72'(es_to_ds_forward_bus), 72'd0);
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;

    // add.w overflow wrap, dest r4
    mk_tx(0, 0, 0, 0, 0, 0, 1, 5'd4, 32'h0, 32'h7fffffff, 32'h1, 32'h1c000000, b, e);
    step(1, b, e, 1, acc);
    // ld.w back-to-back with the add
    mk_tx(0, 1, 0, 0, 1, 0, 1, 5'd5, 32'h10, 32'h1000, 32'h0, 32'h1c000004, b, e);
    step(1, b, e, 1, acc);
    step(0, b, e, 1, acc);
    // st.w held by MS for three cycles
    mk_tx(0, 0, 1, 0, 1, 0, 0, 5'd6, 32'h8, 32'h2000, 32'hdeadbeef, 32'h1c000008, b, e);
    step(1, b, e, 1, acc);
    repeat (3) step(0, b, e, 0, acc);
    step(0, b, e, 1, acc);
    // sra, slt, sltu, lu12i, add to r0, bl
    mk_tx(10, 0, 0, 0, 1, 0, 1, 5'd7, 32'd31, 32'h80000000, 32'h0, 32'h1c00000c, b, e);
    step(1, b, e, 1, acc);
    mk_tx(2, 0, 0, 0, 0, 0, 1, 5'd8, 32'h0, 32'hffffffff, 32'h1, 32'h1c000010, b, e);
    step(1, b, e, 1, acc);
    mk_tx(3, 0, 0, 0, 0, 0, 1, 5'd9, 32'h0, 32'hffffffff, 32'h1, 32'h1c000014, b, e);
    step(1, b, e, 1, acc);
    mk_tx(11, 0, 0, 0, 1, 0, 1, 5'd10, 32'h12345000, 32'h0, 32'h0, 32'h1c000018, b, e);
    step(1, b, e, 1, acc);
    mk_tx(0, 0, 0, 0, 0, 0, 1, 5'd0, 32'h0, 32'h11, 32'h22, 32'h1c00001c, b, e);
    step(1, b, e, 1, acc);
    mk_tx(0, 0, 0, 1, 1, 1, 1, 5'd1, 32'h4, 32'h0, 32'h0, 32'h1c000020, b, e);
    step(1, b, e, 1, acc);
    step(0, b, e, 1, acc);

    // Random traffic with random MS back-pressure and idle gaps
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 12);
      ld = ($urandom_range(0, 5) == 0);
      st = !ld && ($urandom_range(0, 5) == 0);
      if (ld || st) begin
        mk_tx(0, ld, st, 0, 1, 0, ld, 5'($urandom), $urandom, $urandom, $urandom, $urandom, b, e);
      end else begin
        mk_tx(op, 0, 0, 1'($urandom), 1'($urandom), 0, 1'($urandom),
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
              $urandom, $urandom, $urandom, $urandom, b, e);
      end
      if ($urandom_range(0, 3) == 0) step(0, b, e, 1'($urandom_range(0, 1)), acc);
      tries = 0;
      do begin
        step(1, b, e, ($urandom_range(0, 9) < 7), acc);
        tries++;
      end while (!acc && tries < 64);
      if (!acc) check("accept_bound", 72'd0, 72'd1);
    end
    repeat (2) step(0, b, e, 1, acc);

    // Reset asserted mid-cycle while a load is held by an MS stall
    mk_tx(0, 1, 0, 0, 1, 0, 1, 5'd3, 32'h4, 32'h3000, 32'h0, 32'h1c000100, b, e);
    step(1, b, e, 1, acc);
    ds_to_es_valid = 1'b0;
    ms_allowin     = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_ms_valid", 72'(es_to_ms_valid), 72'd0);
    check("arst_ds_valid", 72'(es_to_ds_valid), 72'd0);
    check("arst_sram_en", 72'(data_sram_en), 72'd0);
    check("arst_stall_flag", 72'(es_to_ds_forward_bus[38]), 72'd0);
    exp_q.delete();
    ms_allowin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("arst_hold_sram_en", 72'(data_sram_en), 72'd0);
    #3 resetn = 1'b1;
    repeat (3) step(0, b, e, 1, acc);
    check("final_queue_empty", 72'(exp_q.size()), 72'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
